// File: rtl/temp_sens_pkg.sv
// Shared types and constants for the three-sensor SPI temperature scheduler.
package temp_sens_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD
  } state_t;

  localparam logic [1:0] SENS_1 = 2'd1;
  localparam logic [1:0] SENS_2 = 2'd2;
  localparam logic [1:0] SENS_3 = 2'd3;

  function automatic logic sel_legal(input logic [1:0] sel);
    return sel != 2'd0;
  endfunction

endpackage

// File: rtl/temp_sens_scheduler_spi_rx_shifter.sv
// SPI receive engine: SCK generation, MSB-first sampling on SCK rise, bit count, done pulse.
module spi_rx_shifter
  import temp_sens_pkg::*;
#(
  parameter int unsigned SCK_DIV = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              run,
  input  logic              so,
  output logic              sck,
  output logic [DATA_W-1:0] data,
  output logic [4:0]        count,
  output logic              done
);

  localparam int unsigned DIV_W = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(SCK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] FULL_LAST = DIV_W'(SCK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      sck     <= 1'b0;
      data    <= '0;
      count   <= '0;
    end else begin
      if (run) begin
        if (div_cnt == FULL_LAST) begin
          div_cnt <= '0;
          sck     <= 1'b0;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
        // sample on the same edge that raises SCK
        if (div_cnt == HALF_LAST) begin
          sck   <= 1'b1;
          data  <= {data[DATA_W-2:0], so};
          count <= count + 1'b1;
        end
      end else begin
        div_cnt <= '0;
        sck     <= 1'b0;
      end
      if (clear) begin
        count <= '0;
      end
    end
  end

  assign done = run && (div_cnt == FULL_LAST) && (count == 5'(DATA_W));

endmodule

// File: rtl/temp_sens_scheduler.sv
// Periodic / forced read scheduler for three SPI temperature sensors on a shared SCK/SO bus.
module temp_sens_scheduler
  import temp_sens_pkg::*;
#(
  parameter int unsigned SCK_DIV      = 8,
  parameter int unsigned CS_SETUP_CYC = 2,
  parameter int unsigned CS_HOLD_CYC  = 2
) (
  input  logic        fab_clk_16MHz,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] period,
  input  logic        force_req,
  input  logic [1:0]  force_sel,
  output logic        force_ack,
  output logic        force_err,
  output logic        temp_sck,
  output logic        temp1_csn,
  output logic        temp2_csn,
  output logic        temp3_csn,
  input  logic        temp_so,
  output logic [15:0] temp1,
  output logic [15:0] temp2,
  output logic [15:0] temp3,
  output logic [2:0]  temp_valid,
  output logic [4:0]  temp_count_data,
  output logic        busy
);

  state_t state, state_next;
  logic [1:0]  sel, sel_next;
  logic        is_force, force_next;
  logic [7:0]  phase_cnt;
  logic [1:0]  round_idx;
  logic        sched_pend;
  logic [31:0] pcnt;
  logic        ack_c, err_c, complete, wrap;
  logic        shift_done;
  logic [DATA_W-1:0] shift_data;

  spi_rx_shifter #(.SCK_DIV(SCK_DIV)) u_shifter (
    .clk   (fab_clk_16MHz),
    .rst   (rst),
    .clear (state == CS_SETUP),
    .run   (state == SHIFT),
    .so    (temp_so),
    .sck   (temp_sck),
    .data  (shift_data),
    .count (temp_count_data),
    .done  (shift_done)
  );

  always_comb begin
    state_next = state;
    sel_next   = sel;
    force_next = is_force;
    ack_c      = 1'b0;
    err_c      = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        // forced reads outrank the schedule; a pending round simply waits
        if (force_req) begin
          if (sel_legal(force_sel)) begin
            ack_c      = 1'b1;
            sel_next   = force_sel;
            force_next = 1'b1;
            state_next = CS_SETUP;
          end else begin
            err_c = 1'b1;
          end
        end else if (sched_pend && en) begin
          sel_next   = round_idx;
          force_next = 1'b0;
          state_next = CS_SETUP;
        end
      end
      CS_SETUP: if (phase_cnt == 8'(CS_SETUP_CYC - 1)) state_next = SHIFT;
      SHIFT:    if (shift_done) state_next = CS_HOLD;
      CS_HOLD: begin
        if (phase_cnt == 8'(CS_HOLD_CYC - 1)) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign wrap = en && ((period == 32'd0) ? (state == IDLE) : (pcnt == period - 32'd1));

  always_ff @(posedge fab_clk_16MHz) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= '0;
      is_force   <= 1'b0;
      phase_cnt  <= '0;
      round_idx  <= SENS_1;
      sched_pend <= 1'b0;
      pcnt       <= '0;
      temp1      <= '0;
      temp2      <= '0;
      temp3      <= '0;
      temp_valid <= '0;
      force_ack  <= 1'b0;
      force_err  <= 1'b0;
    end else begin
      state      <= state_next;
      sel        <= sel_next;
      is_force   <= force_next;
      phase_cnt  <= (state_next != state) ? '0 : phase_cnt + 1'b1;
      force_ack  <= ack_c;
      force_err  <= err_c;
      temp_valid <= '0;
      if (complete) begin
        case (sel)
          SENS_1:  begin temp1 <= shift_data; temp_valid <= 3'b001; end
          SENS_2:  begin temp2 <= shift_data; temp_valid <= 3'b010; end
          SENS_3:  begin temp3 <= shift_data; temp_valid <= 3'b100; end
          default: ;
        endcase
      end
      if (en) begin
        pcnt <= (wrap || period == 32'd0) ? '0 : pcnt + 32'd1;
      end
      // later assignments win: a finished or abandoned round beats a coincident wrap
      if (wrap) sched_pend <= 1'b1;
      if (state == IDLE && !en) begin
        sched_pend <= 1'b0;
        round_idx  <= SENS_1;
      end
      if (complete && !is_force) begin
        if (sel == SENS_3 || !en) begin
          sched_pend <= 1'b0;
          round_idx  <= SENS_1;
        end else begin
          round_idx <= sel + 2'd1;
        end
      end
    end
  end

  assign temp1_csn = !(state != IDLE && sel == SENS_1);
  assign temp2_csn = !(state != IDLE && sel == SENS_2);
  assign temp3_csn = !(state != IDLE && sel == SENS_3);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_temp_sens_scheduler.sv
// Directed bench for temp_sens_scheduler with a sensor model, scoreboard and SPI timing monitor.
module tb_temp_sens_scheduler;

  localparam int SCK_DIV = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] period = '0;
  logic        force_req = 1'b0;
  logic [1:0]  force_sel = '0;
  logic        force_ack, force_err, temp_sck;
  logic        temp1_csn, temp2_csn, temp3_csn;
  logic        temp_so = 1'b0;
  logic [15:0] temp1, temp2, temp3;
  logic [2:0]  temp_valid;
  logic [4:0]  temp_count_data;
  logic        busy;

  temp_sens_scheduler #(.SCK_DIV(SCK_DIV), .CS_SETUP_CYC(2), .CS_HOLD_CYC(2)) dut (
    .fab_clk_16MHz   (clk),
    .rst             (rst),
    .en              (en),
    .period          (period),
    .force_req       (force_req),
    .force_sel       (force_sel),
    .force_ack       (force_ack),
    .force_err       (force_err),
    .temp_sck        (temp_sck),
    .temp1_csn       (temp1_csn),
    .temp2_csn       (temp2_csn),
    .temp3_csn       (temp3_csn),
    .temp_so         (temp_so),
    .temp1           (temp1),
    .temp2           (temp2),
    .temp3           (temp3),
    .temp_valid      (temp_valid),
    .temp_count_data (temp_count_data),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;

  typedef struct {
    logic [2:0]  vld;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  logic [15:0] pat1 = '0, pat2 = '0, pat3 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [2:0] vld, input logic [15:0] data);
    exp_t e;
    e.vld  = vld;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int maxc);
    for (int i = 0; i < maxc && sb.size() != 0; i++) step();
    chk(tag, sb.size(), 0);
  endtask

  task automatic wait_any_csn(input string tag, input int maxc);
    int found = 0;
    for (int i = 0; i < maxc && found == 0; i++) begin
      step();
      if (!(temp1_csn && temp2_csn && temp3_csn)) found = 1;
    end
    chk(tag, found, 1);
  endtask

  // Sensor model: shifts its word out MSB-first, advancing after each SCK rise.
  int          bit_i = 0;
  logic        so_prev_sck = 1'b0;
  logic [15:0] cur;
  always @(negedge clk) begin
    if (temp1_csn && temp2_csn && temp3_csn) begin
      bit_i       = 0;
      so_prev_sck = 1'b0;
    end else begin
      if (temp_sck && !so_prev_sck) bit_i++;
      so_prev_sck = temp_sck;
    end
    cur     = !temp1_csn ? pat1 : (!temp2_csn ? pat2 : pat3);
    temp_so = (bit_i < 16) ? cur[15 - bit_i] : 1'b0;
  end

  // Bus timing monitor and scoreboard consumer.
  int   cyc = 0, rises = 0, t_fall = 0, t_first = 0, t_rise = 0, t_lastfall = 0;
  int   t_s1_prev = 0, t_s1_last = 0;
  logic in_txn = 1'b0, bad_period = 1'b0, prev_sck = 1'b0, prev_any = 1'b0, any_low;
  exp_t e;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      in_txn   = 1'b0;
      prev_sck = 1'b0;
      prev_any = 1'b0;
    end else begin
      any_low = !(temp1_csn && temp2_csn && temp3_csn);
      if (any_low) chk("csn_onehot", $countones({~temp1_csn, ~temp2_csn, ~temp3_csn}), 1);
      if (any_low && !prev_any) begin
        in_txn     = 1'b1;
        t_fall     = cyc;
        rises      = 0;
        bad_period = 1'b0;
        if (!temp1_csn) begin
          t_s1_prev = t_s1_last;
          t_s1_last = cyc;
        end
      end
      if (temp_sck && !prev_sck) begin
        if (rises == 0) t_first = cyc;
        else if (cyc - t_rise != SCK_DIV) bad_period = 1'b1;
        t_rise = cyc;
        rises++;
      end
      if (!temp_sck && prev_sck) t_lastfall = cyc;
      if (!any_low && prev_any && in_txn) begin
        chk("sck_pulses", rises, 16);
        chk("sck_period", bad_period, 0);
        chk("csn_to_first_rise", t_first - t_fall, 6);
        chk("last_fall_to_csn", cyc - t_lastfall, 2);
        in_txn = 1'b0;
      end
      if (temp_valid !== 3'b000) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", temp_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("valid_vec", temp_valid, e.vld);
          chk("temp_value", e.vld[0] ? temp1 : (e.vld[1] ? temp2 : temp3), e.data);
          chk("count_at_done", temp_count_data, 16);
        end
      end
      prev_sck = temp_sck;
      prev_any = any_low;
    end
  end

  initial begin
    int found;
    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_csn", {temp1_csn, temp2_csn, temp3_csn}, 3'b111);
    chk("rst_sck", temp_sck, 0);
    chk("rst_temps", {temp1, temp2, temp3}, 0);
    chk("rst_flags", {temp_valid, force_ack, force_err, busy}, 0);
    chk("rst_count", temp_count_data, 0);

    // 1: periodic rounds, period 1000
    pat1 = 16'hA5C3; pat2 = 16'hA5C3; pat3 = 16'hA5C3;
    repeat (2) begin
      push(3'b001, 16'hA5C3); push(3'b010, 16'hA5C3); push(3'b100, 16'hA5C3);
    end
    period = 32'd1000;
    en     = 1'b1;
    wait_drain("round_drain", 2600);
    en = 1'b0;
    chk("round_spacing", t_s1_last - t_s1_prev, 1000);
    repeat (4) step();
    chk("idle_after_rounds", busy, 0);

    // 3: forced read of sensor 2
    pat2 = 16'h1234;
    push(3'b010, 16'h1234);
    force_req = 1'b1; force_sel = 2'd2;
    step();
    chk("force_ack", force_ack, 1);
    chk("force_csn", {temp1_csn, temp2_csn, temp3_csn}, 3'b101);
    force_req = 1'b0;
    step();
    chk("force_ack_pulse", force_ack, 0);
    wait_drain("force_drain", 200);
    chk("force_others", {temp1, temp3}, {16'hA5C3, 16'hA5C3});
    chk("force_temp2", temp2, 16'h1234);

    // 5: illegal force_sel
    force_req = 1'b1; force_sel = 2'd0;
    step();
    chk("err_pulse", force_err, 1);
    chk("err_no_ack", force_ack, 0);
    chk("err_busy", busy, 0);
    chk("err_csn", {temp1_csn, temp2_csn, temp3_csn}, 3'b111);
    force_req = 1'b0;
    step();
    chk("err_pulse_end", {force_err, busy}, 0);

    // 4: force and period wrap in the same IDLE cycle
    reset_dut();
    pat1 = 16'hC001; pat2 = 16'h0220; pat3 = 16'hBEEF;
    push(3'b100, 16'hBEEF);
    push(3'b001, 16'hC001); push(3'b010, 16'h0220); push(3'b100, 16'hBEEF);
    period = 32'd1000;
    en     = 1'b1;
    repeat (999) @(posedge clk);
    #1 force_req = 1'b1; force_sel = 2'd3;
    step();
    chk("tie_ack", force_ack, 1);
    chk("tie_csn", {temp1_csn, temp2_csn, temp3_csn}, 3'b110);
    force_req = 1'b0;
    wait_drain("tie_drain", 700);
    en = 1'b0;
    repeat (4) step();

    // 6: reset at bit 7 of sensor 2
    reset_dut();
    pat1 = 16'h5A5A; pat2 = 16'h3C3C; pat3 = 16'h9999;
    push(3'b001, 16'h5A5A);
    period = 32'd0;
    en     = 1'b1;
    found  = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      step();
      if (!temp2_csn && temp_count_data == 5'd7) found = 1;
    end
    chk("reach_s2_bit7", found, 1);
    chk("s1_done_before_abort", sb.size(), 0);
    reset_dut();
    chk("abort_csn", {temp1_csn, temp2_csn, temp3_csn}, 3'b111);
    chk("abort_sck", temp_sck, 0);
    chk("abort_temp2", temp2, 0);
    chk("abort_flags", {temp_valid, busy}, 0);
    period = 32'd1000;
    push(3'b001, 16'h5A5A); push(3'b010, 16'h3C3C); push(3'b100, 16'h9999);
    wait_any_csn("restart_seen", 1100);
    chk("restart_sensor1", {temp1_csn, temp2_csn, temp3_csn}, 3'b011);
    wait_drain("restart_drain", 600);
    en = 1'b0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
